// File: rtl/accel_bridge_pkg.sv
// Shared types and helpers for the accelerator Avalon-MM master bridge.
package accel_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RD_HOLD = 2'd2
  } state_t;

  // Widest supported command fields; a FIFO entry holds {is_wr, addr, data} in this order.
  localparam int unsigned CMD_ADDR_MAX = 64;
  localparam int unsigned CMD_DATA_MAX = 512;
  localparam int unsigned BE_MAX       = CMD_DATA_MAX / 8;

  typedef struct packed {
    logic                    is_wr;
    logic [CMD_ADDR_MAX-1:0] addr;
    logic [CMD_DATA_MAX-1:0] data;
  } cmd_t;

  function automatic logic [BE_MAX-1:0] be_all_ones();
    return '1;
  endfunction

endpackage

// File: rtl/accel_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with full/empty flags and occupancy count.
module accel_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW:0]      wr_ptr_q, wr_ptr_d;
  logic [PW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  always_comb begin
    count    = wr_ptr_q - rd_ptr_q;
    full     = (count == (PW+1)'(DEPTH));
    empty    = (count == '0);
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + (PW+1)'(do_push);
    rd_ptr_d = rd_ptr_q + (PW+1)'(do_pop);
    dout     = mem_q[rd_ptr_q[PW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is datapath only; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PW-1:0]] <= din;
  end

endmodule

// File: rtl/accel_avalon_master_bridge.sv
// Avalon-MM master bridge for the CNN accelerator memory port: command FIFO, waitrequest,
// pipelined reads with an outstanding limit. Optional perf counters under ACC_BRIDGE_PERF_CNT_EN.
module accel_avalon_master_bridge
  import accel_bridge_pkg::*;
#(
  parameter int unsigned ACC_DATA_WIDTH = 16,
  parameter int unsigned AVM_DATA_WIDTH = 32,
  parameter int unsigned ACC_ADDR_WIDTH = 18,
  parameter int unsigned AVM_ADDR_WIDTH = 32,
  parameter int unsigned CMD_FIFO_DEPTH = 4,
  parameter int unsigned MAX_PENDING_RD = 4,
  parameter int unsigned SIGN_EXTEND    = 1
) (
  input  logic                        AVS_Clk,
  input  logic                        AVS_Reset,
  input  logic [AVM_ADDR_WIDTH-1:0]   BRIDGE_Base_Addr,
  input  logic                        ACC_Re,
  input  logic                        ACC_We,
  input  logic [ACC_ADDR_WIDTH-1:0]   ACC_Addr,
  input  logic [ACC_DATA_WIDTH-1:0]   ACC_Data_Out,
  output logic                        ACC_Ready,
  output logic                        ACC_Rd_Valid,
  output logic [ACC_DATA_WIDTH-1:0]   ACC_Rd_Data,
  output logic [AVM_ADDR_WIDTH-1:0]   AVM_m0_address,
  output logic                        AVM_m0_read,
  output logic                        AVM_m0_write,
  output logic [AVM_DATA_WIDTH-1:0]   AVM_m0_writedata,
  output logic [AVM_DATA_WIDTH/8-1:0] AVM_m0_byteenable,
  input  logic [AVM_DATA_WIDTH-1:0]   AVM_m0_readdata,
  input  logic                        AVM_m0_waitrequest,
  input  logic                        AVM_m0_readdatavalid,
`ifdef ACC_BRIDGE_PERF_CNT_EN
  output logic [31:0]                 BRIDGE_Stall_Cnt,
  output logic [31:0]                 BRIDGE_Wr_Cnt,
  output logic [31:0]                 BRIDGE_Rd_Cnt,
`endif
  output logic                        BRIDGE_Idle,
  output logic                        BRIDGE_Err
);
  localparam int unsigned BYTES = AVM_DATA_WIDTH / 8;
  localparam int unsigned ENT_W = 1 + AVM_ADDR_WIDTH + AVM_DATA_WIDTH;
  localparam int unsigned CNT_W = $clog2(CMD_FIFO_DEPTH) + 1;

  function automatic logic [AVM_DATA_WIDTH-1:0] extend_data(input logic [ACC_DATA_WIDTH-1:0] d);
    logic signed [ACC_DATA_WIDTH-1:0] ds;
    ds = d;
    if (SIGN_EXTEND != 0) extend_data = AVM_DATA_WIDTH'(ds);
    else                  extend_data = AVM_DATA_WIDTH'(d);
  endfunction

  logic                      push, pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0]          fifo_count, fifo_count_nxt;
  logic [ENT_W-1:0]          push_ent, head_ent;
  logic                      head_is_wr;
  logic [AVM_ADDR_WIDTH-1:0] head_addr, scaled_addr;
  logic [AVM_DATA_WIDTH-1:0] head_data;
  state_t                    state_q, state_d;
  logic [3:0]                pend_q, pend_d;
  logic                      rd_blocked, drive, rd_done, wr_done, rsp_ok;
  logic                      rd_valid_q, rd_valid_d, err_q, err_d;
  logic [ACC_DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                      unused_rdata;

  // Accept side: address scaled and data extended at push time, write wins a double strobe.
  always_comb begin
    ACC_Ready   = !fifo_full;
    push        = (ACC_Re || ACC_We) && !fifo_full;
    scaled_addr = AVM_ADDR_WIDTH'(ACC_Addr) * AVM_ADDR_WIDTH'(BYTES);
    push_ent    = {ACC_We, BRIDGE_Base_Addr + scaled_addr, extend_data(ACC_Data_Out)};
  end

  accel_sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (CMD_FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk   (AVS_Clk),
    .rst   (AVS_Reset),
    .push  (push),
    .pop   (pop),
    .din   (push_ent),
    .dout  (head_ent),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Bus side: strobes come from registered state only, so waitrequest never loops back.
  always_comb begin
    {head_is_wr, head_addr, head_data} = head_ent;
    rd_blocked        = !head_is_wr && (pend_q >= 4'(MAX_PENDING_RD));
    drive             = (state_q == ST_ISSUE) && !rd_blocked && !AVS_Reset;
    AVM_m0_read       = drive && !head_is_wr;
    AVM_m0_write      = drive && head_is_wr;
    AVM_m0_address    = drive ? head_addr : '0;
    AVM_m0_writedata  = (drive && head_is_wr) ? head_data : '0;
    AVM_m0_byteenable = BYTES'(be_all_ones());
    pop               = drive && !AVM_m0_waitrequest;
    rd_done           = pop && !head_is_wr;
    wr_done           = pop && head_is_wr;
    rsp_ok            = AVM_m0_readdatavalid && (pend_q != '0);
    fifo_count_nxt    = fifo_count + CNT_W'(push) - CNT_W'(pop);
    unused_rdata      = ^AVM_m0_readdata;
  end

  always_comb begin
    pend_d = pend_q;
    if (rd_done && !rsp_ok)      pend_d = pend_q + 4'd1;
    else if (!rd_done && rsp_ok) pend_d = pend_q - 4'd1;
    // A response with nothing outstanding is an orphan (e.g. from before a reset).
    err_d      = err_q || (ACC_Re && ACC_We) || (AVM_m0_readdatavalid && (pend_q == '0));
    rd_valid_d = rsp_ok;
    rd_data_d  = rsp_ok ? AVM_m0_readdata[ACC_DATA_WIDTH-1:0] : rd_data_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (fifo_count_nxt != '0) state_d = ST_ISSUE;
      ST_ISSUE: begin
        if (fifo_count_nxt == '0)     state_d = ST_IDLE;
        else if (rd_blocked && !rsp_ok) state_d = ST_RD_HOLD;
      end
      ST_RD_HOLD: if (rsp_ok) state_d = ST_ISSUE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge AVS_Clk) begin
    if (AVS_Reset) begin
      state_q    <= ST_IDLE;
      pend_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      err_q      <= err_d;
    end
  end

  assign ACC_Rd_Valid = rd_valid_q;
  assign ACC_Rd_Data  = rd_data_q;
  assign BRIDGE_Err   = err_q;
  assign BRIDGE_Idle  = fifo_empty && (pend_q == '0);

`ifdef ACC_BRIDGE_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (c == '1) ? c : c + 32'd1;
  endfunction

  logic [31:0] stall_cnt_q, stall_cnt_d, wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;

  always_comb begin
    stall_cnt_d = (drive && AVM_m0_waitrequest) ? sat_inc(stall_cnt_q) : stall_cnt_q;
    wr_cnt_d    = wr_done ? sat_inc(wr_cnt_q) : wr_cnt_q;
    rd_cnt_d    = rsp_ok ? sat_inc(rd_cnt_q) : rd_cnt_q;
  end

  always_ff @(posedge AVS_Clk) begin
    if (AVS_Reset) begin
      stall_cnt_q <= '0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
    end
  end

  assign BRIDGE_Stall_Cnt = stall_cnt_q;
  assign BRIDGE_Wr_Cnt    = wr_cnt_q;
  assign BRIDGE_Rd_Cnt    = rd_cnt_q;
`endif

endmodule

// File: tb/tb_accel_avalon_master_bridge.sv
// Randomized self-checking bench for accel_avalon_master_bridge with a queue-based reference model.
module tb_accel_avalon_master_bridge;
  localparam int MAXP = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] base;
  logic        re, we;
  logic [17:0] acc_addr;
  logic [15:0] acc_dout;
  logic        ready, rd_valid, read, write, waitreq, rdv, idle, err;
  logic [15:0] rd_data;
  logic [31:0] address, writedata, readdata;
  logic [3:0]  byteenable;
  logic        ready_b, rd_valid_b, read_b, write_b, idle_b, err_b;
  logic [15:0] rd_data_b;
  logic [31:0] address_b, writedata_b;
  logic [3:0]  byteenable_b;
`ifdef ACC_BRIDGE_PERF_CNT_EN
  logic [31:0] stall_cnt, wr_cnt, rd_cnt, stall_cnt_b, wr_cnt_b, rd_cnt_b;
`endif

  always #5 clk = ~clk;

  accel_avalon_master_bridge dut (
    .AVS_Clk(clk), .AVS_Reset(rst), .BRIDGE_Base_Addr(base),
    .ACC_Re(re), .ACC_We(we), .ACC_Addr(acc_addr), .ACC_Data_Out(acc_dout),
    .ACC_Ready(ready), .ACC_Rd_Valid(rd_valid), .ACC_Rd_Data(rd_data),
    .AVM_m0_address(address), .AVM_m0_read(read), .AVM_m0_write(write),
    .AVM_m0_writedata(writedata), .AVM_m0_byteenable(byteenable),
    .AVM_m0_readdata(readdata), .AVM_m0_waitrequest(waitreq), .AVM_m0_readdatavalid(rdv),
`ifdef ACC_BRIDGE_PERF_CNT_EN
    .BRIDGE_Stall_Cnt(stall_cnt), .BRIDGE_Wr_Cnt(wr_cnt), .BRIDGE_Rd_Cnt(rd_cnt),
`endif
    .BRIDGE_Idle(idle), .BRIDGE_Err(err)
  );

  // Zero-extending twin fed the same stimulus; only its write data is inspected.
  accel_avalon_master_bridge #(.SIGN_EXTEND(0)) dut_zx (
    .AVS_Clk(clk), .AVS_Reset(rst), .BRIDGE_Base_Addr(base),
    .ACC_Re(re), .ACC_We(we), .ACC_Addr(acc_addr), .ACC_Data_Out(acc_dout),
    .ACC_Ready(ready_b), .ACC_Rd_Valid(rd_valid_b), .ACC_Rd_Data(rd_data_b),
    .AVM_m0_address(address_b), .AVM_m0_read(read_b), .AVM_m0_write(write_b),
    .AVM_m0_writedata(writedata_b), .AVM_m0_byteenable(byteenable_b),
    .AVM_m0_readdata(readdata), .AVM_m0_waitrequest(waitreq), .AVM_m0_readdatavalid(rdv),
`ifdef ACC_BRIDGE_PERF_CNT_EN
    .BRIDGE_Stall_Cnt(stall_cnt_b), .BRIDGE_Wr_Cnt(wr_cnt_b), .BRIDGE_Rd_Cnt(rd_cnt_b),
`endif
    .BRIDGE_Idle(idle_b), .BRIDGE_Err(err_b)
  );

  typedef struct { bit is_wr; logic [31:0] addr; logic [31:0] data; } bus_cmd_t;
  typedef struct { logic [31:0] data; int due; } rsp_t;

  bus_cmd_t    exp_cmd_q[$];
  logic [15:0] exp_rd_q[$];
  rsp_t        rsp_q[$];
  logic [31:0] slv_mem [logic [31:0]];
  logic [15:0] mdl_mem [logic [31:0]];
  int n_chk = 0, n_pass = 0;
  int cyc = 0, rd_issued = 0, rd_returned = 0, rd_valid_seen = 0, force_wait = 0;
  int dly_min = 1, dly_max = 1;
  bit rand_wait = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'hA5A5_3C3C;
  endfunction

  // Accelerator-side driver and reference model: the bus sequence and read results are
  // predicted at push time, since the bridge must preserve strict command order.
  task automatic acc_cmd(input bit r, input bit w, input logic [17:0] a, input logic [15:0] d);
    int g = 0;
    bus_cmd_t e;
    logic [31:0] ba, dv;
    re = r; we = w; acc_addr = a; acc_dout = d;
    while (!ready && g < 500) begin @(negedge clk); g++; end
    chk("ready_wait", ready, 1'b1);
    if (ready) begin
      ba = base + 32'(a) * 32'd4;
      e.is_wr = w; e.addr = ba; e.data = {{16{d[15]}}, d};
      exp_cmd_q.push_back(e);
      if (w) mdl_mem[ba] = d;
      else begin
        dv = dflt(ba);
        exp_rd_q.push_back(mdl_mem.exists(ba) ? mdl_mem[ba] : dv[15:0]);
      end
    end
    @(negedge clk);
    re = 1'b0; we = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int g = 0;
    while (!(idle && exp_cmd_q.size() == 0 && exp_rd_q.size() == 0 && rsp_q.size() == 0)
           && g < 3000) begin
      @(negedge clk); g++;
    end
    chk({"drain_", tag}, (g < 3000), 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Avalon slave model plus accelerator read-return checker, all sampled on the falling edge.
  initial begin : slave
    bus_cmd_t e;
    rsp_t r;
    int pend_now;
    logic [31:0] dv;
    waitreq = 1'b0; rdv = 1'b0; readdata = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rd_valid) begin
        rd_valid_seen++;
        if (exp_rd_q.size() == 0) chk("rd_unexpected", rd_valid, 1'b0);
        else chk("rd_data", rd_data, exp_rd_q.pop_front());
      end
      pend_now = rd_issued - rd_returned;
      waitreq = 1'b0;
      if (read || write) begin
        if (force_wait > 0) begin waitreq = 1'b1; force_wait--; end
        else if (rand_wait) waitreq = ($urandom_range(0, 2) == 0);
        if (read) chk("pend_limit", (pend_now < MAXP), 1'b1);
        if (!waitreq) begin
          if (exp_cmd_q.size() == 0) chk("bus_unexpected", read | write, 1'b0);
          else begin
            e = exp_cmd_q.pop_front();
            chk("bus_kind", write, e.is_wr);
            chk("bus_addr", address, e.addr);
            if (write) begin
              chk("bus_wdata", writedata, e.data);
              slv_mem[address] = writedata;
            end else begin
              dv = dflt(address);
              r.data = slv_mem.exists(address) ? slv_mem[address] : dv;
              r.due  = cyc + $urandom_range(dly_min, dly_max);
              rsp_q.push_back(r);
              rd_issued++;
            end
          end
        end
      end
      rdv = 1'b0; readdata = $urandom;
      if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
        rdv = 1'b1; readdata = rsp_q[0].data;
        void'(rsp_q.pop_front());
        rd_returned++;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int s, vs;
    rst = 1'b1; re = 1'b0; we = 1'b0; acc_addr = '0; acc_dout = '0; base = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_idle", idle, 1'b1);
    chk("rst_read", read, 1'b0);
    chk("rst_write", write, 1'b0);
    chk("rst_addr", address, 32'h0);
    chk("rst_wdata", writedata, 32'h0);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_rd_data", rd_data, 16'h0);
    chk("rst_err", err, 1'b0);
    chk("rst_ready", ready, 1'b1);
    chk("byteenable", byteenable, 4'hF);

    // First write: strobe one cycle after push, scaled address, sign/zero extension.
    base = 32'h1000;
    acc_cmd(1'b0, 1'b1, 18'd5, 16'h8001);
    chk("t1_write", write, 1'b1);
    chk("t1_addr", address, 32'h1014);
    chk("t1_wdata_sx", writedata, 32'hFFFF_8001);
    chk("t1_wdata_zx", writedata_b, 32'h0000_8001);
    wait_idle("t1");

    // Read and write together: write wins, error latched.
    acc_cmd(1'b1, 1'b1, 18'd7, 16'h1234);
    chk("both_err", err, 1'b1);
    wait_idle("both");
    do_reset();
    chk("err_cleared", err, 1'b0);

    // Stall: signals held for four cycles, then completion and idle.
    force_wait = 3;
    acc_cmd(1'b0, 1'b1, 18'd9, 16'h0042);
    for (int i = 0; i < 4; i++) begin
      chk("t2_write_held", write, 1'b1);
      chk("t2_addr_held", address, 32'h1024);
      chk("t2_wdata_held", writedata, 32'h0000_0042);
      @(negedge clk);
    end
    chk("t2_write_done", write, 1'b0);
    chk("t2_idle", idle, 1'b1);

    // FIFO full behind a stalled head refuses further pushes.
    force_wait = 20;
    for (int i = 0; i < 4; i++) acc_cmd(1'b0, 1'b1, 18'(40 + i), 16'(i));
    chk("full_ready", ready, 1'b0);
    chk("full_head_held", write, 1'b1);
    acc_cmd(1'b0, 1'b1, 18'd44, 16'h0ABC);
    wait_idle("full");

    // Six reads with slow responses: only MAX_PENDING_RD go out before the first return.
    dly_min = 10; dly_max = 10;
    s = rd_issued;
    for (int i = 0; i < 6; i++) acc_cmd(1'b1, 1'b0, 18'(20 + i), 16'h0);
    repeat (2) @(negedge clk);
    chk("t3_issued", rd_issued - s, MAXP);
    chk("t3_hold", read, 1'b0);
    wait_idle("t3");

    // Responses landing on the same cycle as new read completions.
    dly_min = 4; dly_max = 4;
    for (int i = 0; i < 8; i++) acc_cmd(1'b1, 1'b0, 18'(i), 16'h0);
    wait_idle("samecyc");

    // Reset with two reads outstanding, then an orphan response.
    dly_min = 20; dly_max = 20;
    s = rd_issued;
    acc_cmd(1'b1, 1'b0, 18'd3, 16'h0);
    acc_cmd(1'b1, 1'b0, 18'd4, 16'h0);
    repeat (2) @(negedge clk);
    chk("t4_outstanding", rd_issued - s, 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_cmd_q.delete();
    exp_rd_q.delete();
    while (rsp_q.size() > 1) void'(rsp_q.pop_back());
    rsp_q[0].due = cyc + 2;
    rd_issued = rd_returned + 1;
    vs = rd_valid_seen;
    chk("t4_strobes_after_rst", read | write, 1'b0);
    repeat (5) @(negedge clk);
    chk("t4_no_rd_valid", rd_valid_seen - vs, 0);
    chk("t4_err", err, 1'b1);
    chk("t4_rd_data", rd_data, 16'h0);
    chk("t4_strobes", read | write, 1'b0);
    do_reset();
    chk("t4_err_cleared", err, 1'b0);

`ifdef ACC_BRIDGE_PERF_CNT_EN
    dly_min = 2; dly_max = 2;
    force_wait = 5;
    acc_cmd(1'b0, 1'b1, 18'd60, 16'h1111);
    acc_cmd(1'b0, 1'b1, 18'd61, 16'h2222);
    acc_cmd(1'b1, 1'b0, 18'd60, 16'h0);
    wait_idle("perf");
    chk("perf_stall", stall_cnt, 32'd5);
    chk("perf_wr", wr_cnt, 32'd2);
    chk("perf_rd", rd_cnt, 32'd1);
`endif

    // Random traffic: mixed reads/writes, random stalls, response delays and bases (incl. wrap).
    rand_wait = 1'b1;
    dly_min = 1; dly_max = 6;
    for (int i = 0; i < 200; i++) begin
      int k;
      k = $urandom_range(0, 9);
      case ($urandom_range(0, 3))
        0:       base = 32'h0;
        1:       base = 32'h1000;
        2:       base = 32'hFFFF_FFF0;
        default: base = $urandom & 32'hFFFF_FFFC;
      endcase
      if (k < 4)      acc_cmd(1'b1, 1'b0, 18'($urandom_range(0, 15)), 16'h0);
      else if (k < 8) acc_cmd(1'b0, 1'b1, 18'($urandom_range(0, 15)), 16'($urandom));
      else            @(negedge clk);
    end
    wait_idle("random");
    rand_wait = 1'b0;
    chk("random_err", err, 1'b0);
    chk("final_cmd_q", exp_cmd_q.size(), 0);
    chk("final_rd_q", exp_rd_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/accel_avalon_master_bridge.md
Name: accel_avalon_master_bridge

Overview:
- Parametrised Avalon-MM master bridge between the CNN accelerator's memory port (word-indexed read/write strobes) and the system interconnect.
- Successor to the fixed 16/32-bit combinational master path. It adds:
  - a command FIFO;
  - honouring of waitrequest;
  - pipelined reads with readdatavalid and an outstanding-read limit;
  - configurable widths, address scaling and a base offset;
  - back-pressure to the accelerator.

Parameters:
- ACC_DATA_WIDTH, 16, accelerator data width (must be ≤ AVM_DATA_WIDTH).
- AVM_DATA_WIDTH, 32, Avalon data width (multiple of 8).
- ACC_ADDR_WIDTH, 18, accelerator word-index width.
- AVM_ADDR_WIDTH, 32, Avalon byte-address width.
- CMD_FIFO_DEPTH, 4, command FIFO entries (power of 2, ≥ 2).
- MAX_PENDING_RD, 4, maximum reads issued but not yet returned (1..15).
- SIGN_EXTEND, 1, 1 = sign-extend write data to AVM_DATA_WIDTH; 0 = zero-extend.

Ports:
- AVS_Clk  in  1  clock.
- AVS_Reset  in  1  synchronous, active-high reset.
- BRIDGE_Base_Addr  in  AVM_ADDR_WIDTH  byte base address. Sampled per command at push.
- ACC_Re  in  1  read request.
- ACC_We  in  1  write request.
- ACC_Addr  in  ACC_ADDR_WIDTH  word index.
- ACC_Data_Out  in  ACC_DATA_WIDTH  write data.
- ACC_Ready  out  1  command accepted this cycle if a strobe is high.
- ACC_Rd_Valid  out  1  read data valid.
- ACC_Rd_Data  out  ACC_DATA_WIDTH  read data.
- AVM_m0_address  out  AVM_ADDR_WIDTH  byte address.
- AVM_m0_read  out  1  Avalon read.
- AVM_m0_write  out  1  Avalon write.
- AVM_m0_writedata  out  AVM_DATA_WIDTH  Avalon write data.
- AVM_m0_byteenable  out  AVM_DATA_WIDTH/8  byte enables (all ones).
- AVM_m0_readdata  in  AVM_DATA_WIDTH  Avalon read data.
- AVM_m0_waitrequest  in  1  slave stall.
- AVM_m0_readdatavalid  in  1  read response strobe.
- BRIDGE_Idle  out  1  FIFO empty, nothing outstanding, no command on the bus.
- BRIDGE_Err  out  1  sticky error; cleared only by reset.

Behaviour:
- Reset values:
  - All Avalon strobes 0; address and writedata 0.
  - ACC_Rd_Valid 0, ACC_Rd_Data 0, BRIDGE_Err 0, BRIDGE_Idle 1.
  - FIFO emptied, outstanding counter 0.
- Reset mid-transfer aborts the held command. Responses that arrive afterwards with counter = 0 are dropped and set BRIDGE_Err.
- Accept rule: ACC_Ready = !fifo_full (combinational from registered state).
  - Push occurs when (ACC_Re | ACC_We) & ACC_Ready.
  - ACC_Re & ACC_We together: the write wins, the read is ignored, and BRIDGE_Err is set.
- Address: base + ACC_Addr × (AVM_DATA_WIDTH/8), computed at push, truncated modulo 2^AVM_ADDR_WIDTH (wraps silently).
- Write data: ACC_Data_Out extended per SIGN_EXTEND.
- Issue FSM states:
  - IDLE: FIFO empty. Moves to ISSUE when non-empty.
  - ISSUE: drives the head command on the bus.
    - A read head is driven only if outstanding < MAX_PENDING_RD. Otherwise go to RD_HOLD with strobes 0.
    - Command completes on the first cycle with waitrequest = 0: pop, then ISSUE if FIFO still non-empty, else IDLE.
  - RD_HOLD: waits for a response to free a slot, then returns to ISSUE.
- Signals stay stable while waitrequest = 1 (address, data, strobe unchanged).
- Latency: push in cycle N → earliest bus strobe in cycle N+1. Back-to-back commands on consecutive cycles when waitrequest = 0.
- Outstanding counter:
  - +1 when a read completes its command phase.
  - −1 on readdatavalid.
  - Both in the same cycle: unchanged.
- Read return:
  - ACC_Rd_Valid pulses one cycle after readdatavalid.
  - ACC_Rd_Data = readdata[ACC_DATA_WIDTH-1:0].
  - Responses are in order; no accelerator back-pressure on responses.
- Ordering: strictly FIFO order; no write bypass of reads.
- FIFO full with a pop in the same cycle: the push is still refused (ACC_Ready is based on full only).

Optional Feature:
- Macro ACC_BRIDGE_PERF_CNT_EN.
- When defined, adds three 32-bit outputs:
  - BRIDGE_Stall_Cnt: cycles with strobe & waitrequest.
  - BRIDGE_Wr_Cnt: completed writes.
  - BRIDGE_Rd_Cnt: returned reads.
- Counters reset to 0 and saturate at all ones.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package accel_bridge_pkg:
  - command typedef {is_wr, addr, data};
  - FSM state encoding (IDLE, ISSUE, RD_HOLD);
  - byte-enable all-ones constant helper.
- One sub-module, accel_sync_fifo: parametrised width/depth, synchronous reset, full/empty flags, first-word-fall-through head.

Test Plan:
- Defaults, base 0x1000: write ACC_Addr=5, data 0x8001, waitrequest=0 → cycle+1: write=1, address 0x1014, writedata 0xFFFF8001. With SIGN_EXTEND=0 → writedata 0x00008001.
- Push a write, hold waitrequest=1 for 3 cycles → strobe, address and data constant for 4 cycles; pop on the 4th; BRIDGE_Idle=1 after.
- 6 reads back-to-back, MAX_PENDING_RD=4, responses delayed 10 cycles → exactly 4 read strobes, then RD_HOLD. ACC_Ready=0 while full. ACC_Rd_Data returns 6 values in issue order.
- Readdatavalid in the same cycle as a read completes → outstanding count unchanged (checked via issue gating).
- Assert reset with 2 reads outstanding, then deliver 1 readdatavalid → no ACC_Rd_Valid; BRIDGE_Err=1; strobes 0.
- With ACC_BRIDGE_PERF_CNT_EN: 5 waitrequest cycles, 2 writes, 1 read → Stall=5, Wr=2, Rd=1.
